// File: rtl/enigma_pkg.sv
// Shared definitions for the enigma stream controller: letter range, FSM
// state encoding and the letter test used when scanning the source RAM.
package enigma_pkg;

    localparam int LETTER_MIN = 1;
    localparam int LETTER_MAX = 26;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CHECK = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic is_letter(input logic [31:0] s);
        return (s >= 32'(LETTER_MIN)) && (s <= 32'(LETTER_MAX));
    endfunction

endpackage

// File: rtl/enigma_sp_ram.sv
// DEPTH x WIDTH RAM with one write port and one read port whose address is
// registered, so read data follows the address by one clock.
module enigma_sp_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 6,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    raddr_q;

    // No reset on purpose: contents must survive a controller reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_q <= raddr;
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/enigma_stream_ctrl.sv
// Scans a message in the source RAM, sends each letter (1..26) to the cipher
// core and stores the core's results contiguously in the destination RAM.
module enigma_stream_ctrl
    import enigma_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int SYMB_W = 6,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [AW:0]       len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW:0]       out_cnt_o,
    input  logic              src_we_i,
    input  logic [AW-1:0]     src_addr_i,
    input  logic [SYMB_W-1:0] src_data_i,
    input  logic [AW-1:0]     dst_addr_i,
    output logic [SYMB_W-1:0] dst_data_o,
    output logic [SYMB_W-1:0] core_s_o,
    output logic              core_valid_o,
    input  logic              core_ready_i,
    input  logic [SYMB_W-1:0] core_s_i,
    input  logic              core_valid_i
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e            state_q;
    logic [AW:0]       len_eff_q;
    logic [AW:0]       rd_idx_q;
    logic [AW:0]       out_cnt_q;
    logic [SYMB_W-1:0] core_s_q;
    logic              done_q;

    logic [AW:0]       len_clamp;
    logic [AW:0]       rd_idx_nxt;
    logic              last_entry;
    logic              src_we;
    logic              dst_we;
    logic [SYMB_W-1:0] src_rdata;

    assign len_clamp  = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign rd_idx_nxt = rd_idx_q + (AW+1)'(1);
    assign last_entry = (rd_idx_nxt == len_eff_q);

    // Host writes only land while idle so a running scan sees a frozen message.
    assign src_we = src_we_i && (state_q == ST_IDLE);
    assign dst_we = core_valid_i && (state_q == ST_WAIT);

    enigma_sp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SYMB_W)
    ) u_src_ram (
        .clk_i (clk_i),
        .we    (src_we),
        .waddr (src_addr_i),
        .wdata (src_data_i),
        .raddr (rd_idx_q[AW-1:0]),
        .rdata (src_rdata)
    );

    enigma_sp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SYMB_W)
    ) u_dst_ram (
        .clk_i (clk_i),
        .we    (dst_we),
        .waddr (out_cnt_q[AW-1:0]),
        .wdata (core_s_i),
        .raddr (dst_addr_i),
        .rdata (dst_data_o)
    );

    // Handshake: a symbol transfers on a cycle with core_valid_o and
    // core_ready_i both high; core_s_o is held while valid waits for ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            len_eff_q <= '0;
            rd_idx_q  <= '0;
            out_cnt_q <= '0;
            core_s_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_eff_q <= len_clamp;
                        rd_idx_q  <= '0;
                        out_cnt_q <= '0;
                        state_q   <= (len_clamp == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (is_letter(32'(src_rdata))) begin
                        core_s_q <= src_rdata;
                        state_q  <= ST_SEND;
                    end else begin
                        rd_idx_q <= rd_idx_nxt;
                        state_q  <= last_entry ? ST_DONE : ST_FETCH;
                    end
                end
                ST_SEND: begin
                    if (core_ready_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_valid_i) begin
                        out_cnt_q <= out_cnt_q + (AW+1)'(1);
                        rd_idx_q  <= rd_idx_nxt;
                        state_q   <= last_entry ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign out_cnt_o    = out_cnt_q;
    assign core_s_o     = core_s_q;
    assign core_valid_o = (state_q == ST_SEND);

endmodule

// File: tb/tb_enigma_stream_ctrl.sv
// Directed bench for enigma_stream_ctrl: a behavioural cipher core returns s+1
// and every result is compared against hand-computed values.
module tb_enigma_stream_ctrl;

    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW:0]   len_i;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   out_cnt_o;
    logic          src_we_i;
    logic [AW-1:0] src_addr_i;
    logic [5:0]    src_data_i;
    logic [AW-1:0] dst_addr_i;
    logic [5:0]    dst_data_o;
    logic [5:0]    core_s_o;
    logic          core_valid_o;
    logic          core_ready_i;
    logic [5:0]    core_s_i;
    logic          core_valid_i;

    int n_checks;
    int n_errors;

    int r_valid_first;
    int r_valid_cyc;
    int r_done_cyc;
    int r_dones;
    int r_sends;
    bit r_sym_stable;

    enigma_stream_ctrl #(.DEPTH(16), .SYMB_W(6)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .out_cnt_o    (out_cnt_o),
        .src_we_i     (src_we_i),
        .src_addr_i   (src_addr_i),
        .src_data_i   (src_data_i),
        .dst_addr_i   (dst_addr_i),
        .dst_data_o   (dst_data_o),
        .core_s_o     (core_s_o),
        .core_valid_o (core_valid_o),
        .core_ready_i (core_ready_i),
        .core_s_i     (core_s_i),
        .core_valid_i (core_valid_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_src(input int addr, input int data);
        src_addr_i = addr[AW-1:0];
        src_data_i = data[5:0];
        src_we_i   = 1'b1;
        tick();
        src_we_i   = 1'b0;
    endtask

    task automatic chk_dst(input string tag, input int addr, input int exp);
        dst_addr_i = addr[AW-1:0];
        tick();
        chk(tag, 32'(dst_data_o), exp[31:0]);
    endtask

    // Starts a run (cycle 0 = start cycle) and plays the cipher core until two
    // cycles after done_o or until the budget expires. stall = SEND cycles with
    // ready low per symbol; spurious drives core_valid_i during SEND; inj_cyc
    // issues a start plus a source write (src[1] = 0) while busy.
    task automatic run_msg(input int len, input int stall, input bit spurious,
                           input int inj_cyc, input int budget);
        int         stall_cnt;
        int         stop;
        bit         pending;
        logic [5:0] psym;
        logic [5:0] held;
        stall_cnt     = 0;
        pending       = 1'b0;
        psym          = '0;
        held          = '0;
        r_valid_first = -1;
        r_valid_cyc   = 0;
        r_done_cyc    = -1;
        r_dones       = 0;
        r_sends       = 0;
        r_sym_stable  = 1'b1;
        start_i       = 1'b1;
        len_i         = len[AW:0];
        core_ready_i  = (stall == 0);
        tick();
        stop = budget;
        for (int c = 1; c <= stop; c++) begin
            start_i      = 1'b0;
            src_we_i     = 1'b0;
            core_valid_i = 1'b0;
            if (c == inj_cyc) begin
                start_i    = 1'b1;
                len_i      = 5'd1;
                src_we_i   = 1'b1;
                src_addr_i = 4'd1;
                src_data_i = 6'd0;
            end
            if (pending) begin
                core_valid_i = 1'b1;
                core_s_i     = psym + 6'd1;
                pending      = 1'b0;
            end
            if (done_o) begin
                r_dones++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = c;
                    stop       = c + 2;
                end
            end
            if (core_valid_o) begin
                if (r_valid_first < 0) r_valid_first = c;
                r_valid_cyc++;
                if (stall_cnt == 0) held = core_s_o;
                else if (core_s_o !== held) r_sym_stable = 1'b0;
                if (spurious) begin
                    core_valid_i = 1'b1;
                    core_s_i     = 6'd63;
                end
                if (stall_cnt < stall) begin
                    core_ready_i = 1'b0;
                    stall_cnt++;
                end else begin
                    core_ready_i = 1'b1;
                    pending      = 1'b1;
                    psym         = core_s_o;
                    r_sends++;
                    stall_cnt    = 0;
                end
            end else begin
                core_ready_i = (stall == 0);
            end
            tick();
        end
        start_i      = 1'b0;
        src_we_i     = 1'b0;
        core_valid_i = 1'b0;
        core_ready_i = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        len_i        = '0;
        src_we_i     = 1'b0;
        src_addr_i   = '0;
        src_data_i   = '0;
        dst_addr_i   = '0;
        core_ready_i = 1'b1;
        core_valid_i = 1'b0;
        core_s_i     = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_valid", 32'(core_valid_o), 0);
        chk("rst_core_s", 32'(core_s_o), 0);
        chk("rst_out_cnt", 32'(out_cnt_o), 0);
        rst_i = 1'b0;
        tick();

        // Three letters, ready tied high.
        write_src(0, 1);
        write_src(1, 2);
        write_src(2, 3);
        run_msg(3, 0, 1'b0, 0, 100);
        chk("basic_valid_lat", 32'(r_valid_first), 3);
        chk("basic_done_cyc", 32'(r_done_cyc), 14);
        chk("basic_dones", 32'(r_dones), 1);
        chk("basic_sends", 32'(r_sends), 3);
        chk("basic_out_cnt", 32'(out_cnt_o), 3);
        chk("basic_busy_end", 32'(busy_o), 0);
        chk_dst("basic_dst0", 0, 2);
        chk_dst("basic_dst1", 1, 3);
        chk_dst("basic_dst2", 2, 4);

        // Start and source write while busy are dropped.
        run_msg(3, 0, 1'b0, 2, 100);
        chk("busy_inj_dones", 32'(r_dones), 1);
        chk("busy_inj_out_cnt", 32'(out_cnt_o), 3);
        run_msg(3, 0, 1'b0, 0, 100);
        chk("busy_inj_src_kept", 32'(out_cnt_o), 3);
        chk_dst("busy_inj_dst1", 1, 3);

        // Non-letters are skipped.
        write_src(0, 0);
        write_src(1, 5);
        write_src(2, 27);
        write_src(3, 63);
        write_src(4, 26);
        run_msg(5, 0, 1'b0, 0, 100);
        chk("skip_valid_first", 32'(r_valid_first), 5);
        chk("skip_sends", 32'(r_sends), 2);
        chk("skip_dones", 32'(r_dones), 1);
        chk("skip_out_cnt", 32'(out_cnt_o), 2);
        chk_dst("skip_dst0", 0, 6);
        chk_dst("skip_dst1", 1, 27);
        chk_dst("skip_dst2_kept", 2, 4);

        // Ready low for 4 SEND cycles, with core_valid_i asserted during SEND.
        write_src(0, 10);
        run_msg(1, 4, 1'b1, 0, 100);
        chk("stall_sends", 32'(r_sends), 1);
        chk("stall_valid_cyc", 32'(r_valid_cyc), 5);
        chk("stall_sym_stable", 32'(r_sym_stable), 1);
        chk("stall_out_cnt", 32'(out_cnt_o), 1);
        chk("stall_dones", 32'(r_dones), 1);
        chk_dst("stall_dst0", 0, 11);

        // Zero-length run.
        run_msg(0, 0, 1'b0, 0, 20);
        chk("len0_done_cyc", 32'(r_done_cyc), 2);
        chk("len0_valid_cyc", 32'(r_valid_cyc), 0);
        chk("len0_dones", 32'(r_dones), 1);
        chk("len0_out_cnt", 32'(out_cnt_o), 0);

        // Length above DEPTH is clamped to 16 entries.
        for (int i = 0; i < 16; i++) write_src(i, i + 1);
        run_msg(20, 0, 1'b0, 0, 300);
        chk("clamp_sends", 32'(r_sends), 16);
        chk("clamp_out_cnt", 32'(out_cnt_o), 16);
        chk("clamp_done_cyc", 32'(r_done_cyc), 66);
        chk("clamp_dones", 32'(r_dones), 1);
        chk_dst("clamp_dst0", 0, 2);
        chk_dst("clamp_dst15", 15, 17);

        // Reset while waiting for the core result.
        write_src(0, 5);
        start_i      = 1'b1;
        len_i        = 5'd1;
        core_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("rstw_send_valid", 32'(core_valid_o), 1);
        tick();
        chk("rstw_wait_busy", 32'(busy_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstw_busy", 32'(busy_o), 0);
        chk("rstw_done", 32'(done_o), 0);
        chk("rstw_valid", 32'(core_valid_o), 0);
        chk("rstw_core_s", 32'(core_s_o), 0);
        chk("rstw_out_cnt", 32'(out_cnt_o), 0);
        tick();
        chk("rstw_no_done", 32'(done_o), 0);
        run_msg(1, 0, 1'b0, 0, 50);
        chk("rstw_rerun_dones", 32'(r_dones), 1);
        chk("rstw_rerun_out_cnt", 32'(out_cnt_o), 1);
        chk_dst("rstw_rerun_dst0", 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
